puf_response_tx: RTL and testbench
==================================

# puf_response_tx

- Serial transmitter for the PUF response byte.
- Waits for the response buffer to flag a complete 8-bit response (`ready_to_read`), then latches the byte and sends it to the host PC as one 8N1 UART frame on `tx`.
- Afterwards it holds a sticky `sent` flag until the host's acknowledge pulse (`computer_ack_reset`) clears it together with the buffer.
- It sits between the response buffer and the board's UART TX pin, and is the host-facing end of the response path.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 434: clock cycles per UART bit (50 MHz / 115200). Must be ≥ 2.

Ports:
- `clock`  in  1  system clock; all logic on its rising edge.
- `computer_ack_reset`  in  1  reset, asynchronous, active-high.
- `ready_to_read`  in  1  level from the response buffer; high when `data_in` holds a complete response.
- `data_in`  in  8  response byte from the buffer.
- `tx`  out  1  UART serial line. Idle high. Registered.
- `busy`  out  1  high while a frame is on the line.
- `sent`  out  1  sticky; high once a frame has completed, until reset.
- `state_dbg`  out  3  current FSM state encoding, for on-board LEDs/SignalTap.

## Operation
FSM states and encodings:
- IDLE=0, START=1, DATA=2, PARITY=3 (only with macro), STOP=4, DONE=5.

Reset values:
- `tx`=1, `busy`=0, `sent`=0, state=IDLE.
- Baud counter, bit index and shift register all 0.

State behaviour:
- **IDLE:** `tx`=1.
  - On an edge where `ready_to_read`=1, latch `data_in` into the shift register, enter START and clear the baud counter.
  - `ready_to_read`=0 keeps the FSM in IDLE.
- **START:** `tx`=0 for `CLKS_PER_BIT` cycles, then DATA with bit index 0.
- **DATA:** `tx`=shift[0], held `CLKS_PER_BIT` cycles. Shift right and increment the bit index at each bit boundary.
  - After bit index 7 completes: go to PARITY if enabled, else STOP.
- **PARITY:** `tx`=even parity of the latched byte (XOR of its 8 bits), held `CLKS_PER_BIT` cycles, then STOP.
- **STOP:** `tx`=1 for `CLKS_PER_BIT` cycles, then DONE.
- **DONE:** `tx`=1, `busy`=0, `sent`=1.
  - The FSM stays here until reset.
  - There is no retransmit even if `ready_to_read` stays high. One frame is sent per acknowledge cycle.

Arithmetic and widths:
- Baud counter is `$clog2(CLKS_PER_BIT)` bits, counts 0..`CLKS_PER_BIT`-1, and wraps to 0 at each bit boundary.
- Bit index is 3 bits.

Boundary conditions:
- `data_in` changes mid-frame: ignored; the latched copy is transmitted.
- `ready_to_read` falls mid-frame: ignored; the frame completes and `sent` asserts.
- Reset mid-frame: `tx` goes to 1 asynchronously and the partial frame is aborted. After release, a new frame starts only when `ready_to_read`=1 is sampled.
- Reset released while `ready_to_read`=1: the frame starts on the first rising edge after release.
- Illegal state encodings (6, 7): next state is IDLE with `tx`=1.

## Timing
- **Start latency:** `tx` falls and `busy` rises on the same rising edge at which IDLE samples `ready_to_read`=1, i.e. one register delay.
- **Bit timing:** every bit holds exactly `CLKS_PER_BIT` cycles with no jitter.
- **Frame length:** 10×`CLKS_PER_BIT` cycles, or 11× with parity.
- **Completion:** `sent` rises and `busy` falls on the edge that ends the stop bit, frame-length cycles after `tx` fell.
- **Glitch-free line:** `tx` is driven only from a flop, so no combinational glitch reaches the pin.

## Configuration
- Macro: `PUF_TX_PARITY_EN`.
- **Defined:** the PARITY state is compiled in. The frame is 8E1: start, 8 data bits LSB first, even-parity bit, stop; 11 bit-times.
- **Undefined:** the PARITY state and parity logic are absent, and the frame is 8N1 (10 bit-times). DATA goes directly to STOP.

## Test plan
All scenarios use `CLKS_PER_BIT`=4.
- **Basic frame, 0xA5, macro off:** `ready_to_read` 0→1. `tx` samples each 4 cycles are 0,1,0,1,0,0,1,0,1,1; `busy` high for 40 cycles; `sent`=1 on cycle 40 and stays.
- **Parity, macro on:** 0xA5 gives parity bit 0 and a 44-cycle frame; 0x07 gives parity bit 1.
- **Hold / no retransmit:** `ready_to_read` held high for 200 cycles after DONE. No second start bit; `tx` stays 1.
- **Mid-frame input changes:** `data_in` changed to 0x00 and `ready_to_read` dropped during bit 3. The transmitted byte is still 0xA5 and `sent` asserts.
- **Reset mid-frame:** `computer_ack_reset` pulsed during bit 5. `tx`=1, `busy`=0, `sent`=0 immediately, then a clean full frame after release with `ready_to_read`=1.
- **Back-to-back ack cycles:** two frames, 0x3C then 0xF0, separated by a reset pulse. Both decode correctly and `sent` toggles 1→0→1.

Source files
------------

// File: rtl/puf_response_tx.sv
// UART transmitter for the PUF response byte: sends one 8N1 frame (8E1 when PUF_TX_PARITY_EN
// is defined) per acknowledge cycle, then holds a sticky sent flag until computer_ack_reset.
module puf_response_tx #(
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic       clock,
  input  logic       computer_ack_reset,
  input  logic       ready_to_read,
  input  logic [7:0] data_in,
  output logic       tx,
  output logic       busy,
  output logic       sent,
  output logic [2:0] state_dbg
);

  localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StStart  = 3'd1,
    StData   = 3'd2,
`ifdef PUF_TX_PARITY_EN
    StParity = 3'd3,
`endif
    StStop   = 3'd4,
    StDone   = 3'd5
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [7:0]      shift_q, shift_d;
  logic            tx_q, tx_d;
  logic            bit_end;
`ifdef PUF_TX_PARITY_EN
  logic            parity_q, parity_d;
`endif

  assign bit_end = (cnt_q == CntMax);

  // State register; tx is a flop so the pin never sees a combinational glitch.
  always_ff @(posedge clock or posedge computer_ack_reset) begin
    if (computer_ack_reset) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      tx_q      <= 1'b1;
`ifdef PUF_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
`ifdef PUF_TX_PARITY_EN
      parity_q  <= parity_d;
`endif
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
`ifdef PUF_TX_PARITY_EN
    parity_d  = parity_q;
`endif
    case (state_q)
      StIdle: begin
        if (ready_to_read) begin
          state_d = StStart;
          cnt_d   = '0;
          shift_d = data_in;
`ifdef PUF_TX_PARITY_EN
          parity_d = ^data_in;
`endif
        end
      end
      StStart: begin
        if (bit_end) begin
          state_d   = StData;
          cnt_d     = '0;
          bit_idx_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StData: begin
        if (bit_end) begin
          cnt_d     = '0;
          shift_d   = {1'b0, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
`ifdef PUF_TX_PARITY_EN
            state_d = StParity;
`else
            state_d = StStop;
`endif
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`ifdef PUF_TX_PARITY_EN
      StParity: begin
        if (bit_end) begin
          state_d = StStop;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`endif
      StStop: begin
        if (bit_end) begin
          state_d = StDone;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StDone: begin
        state_d = StDone;
      end
      default: begin
        state_d   = StIdle;
        cnt_d     = '0;
        bit_idx_d = '0;
      end
    endcase
  end

  // Line level is computed from the upcoming state so tx changes on the same edge as the state.
  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      StStart:  tx_d = 1'b0;
      StData:   tx_d = shift_d[0];
`ifdef PUF_TX_PARITY_EN
      StParity: tx_d = parity_d;
`endif
      default:  tx_d = 1'b1;
    endcase

    busy = 1'b0;
    case (state_q)
      StStart, StData, StStop: busy = 1'b1;
`ifdef PUF_TX_PARITY_EN
      StParity:                busy = 1'b1;
`endif
      default:                 busy = 1'b0;
    endcase

    sent      = (state_q == StDone);
    state_dbg = state_q;
    tx        = tx_q;
  end

endmodule

// File: tb/tb_puf_response_tx.sv
// Bench for puf_response_tx: frame-position reference model checked every cycle, plus literal
// frame checks. Honors PUF_TX_PARITY_EN for 8E1 framing.
module tb_puf_response_tx;

  localparam int C = 4;
`ifdef PUF_TX_PARITY_EN
  localparam bit HasParity = 1'b1;
`else
  localparam bit HasParity = 1'b0;
`endif
  localparam int FB = HasParity ? 11 : 10;

  logic       clock = 1'b0;
  logic       rst = 1'b1;
  logic       ready_to_read = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic       tx, busy, sent;
  logic [2:0] state_dbg;

  int compared = 0;
  int mismatched = 0;

  puf_response_tx #(.CLKS_PER_BIT(C)) dut (
    .clock              (clock),
    .computer_ack_reset (rst),
    .ready_to_read      (ready_to_read),
    .data_in            (data_in),
    .tx                 (tx),
    .busy               (busy),
    .sent               (sent),
    .state_dbg          (state_dbg)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Frame position p in 0..FB-1: start, 8 data bits LSB first, optional parity, stop.
  function automatic logic fbit(input logic [7:0] b, input int p);
    if (p == 0) return 1'b0;
    if (p <= 8) return b[p-1];
    if (HasParity && p == 9) return ^b;
    return 1'b1;
  endfunction

  // Reference model: is a frame active, how many cycles into it, which byte, and is it done.
  logic       m_active = 1'b0;
  logic       m_done = 1'b0;
  logic [7:0] m_byte = 8'h00;
  int         m_k = 0;

  always @(posedge clock or posedge rst) begin
    if (rst) begin
      m_active <= 1'b0;
      m_done   <= 1'b0;
      m_k      <= 0;
    end else if (m_active) begin
      m_k <= m_k + 1;
      if (m_k + 1 == FB * C) begin
        m_active <= 1'b0;
        m_done   <= 1'b1;
      end
    end else if (!m_done && ready_to_read) begin
      m_active <= 1'b1;
      m_byte   <= data_in;
      m_k      <= 0;
    end
  end

  always @(negedge clock) begin
    int   pos;
    logic exp_tx;
    int   exp_st;
    pos    = m_k / C;
    exp_tx = m_active ? fbit(m_byte, pos) : 1'b1;
    if (m_done)              exp_st = 5;
    else if (!m_active)      exp_st = 0;
    else if (pos == 0)       exp_st = 1;
    else if (pos <= 8)       exp_st = 2;
    else if (pos == FB - 1)  exp_st = 4;
    else                     exp_st = 3;
    check("tx", tx, exp_tx);
    check("busy", busy, m_active);
    check("sent", sent, m_done);
    check("state_dbg", state_dbg, exp_st);
  end

  // Samples tx mid-bit for one frame; optionally perturbs inputs at cycle change_at.
  task automatic sample_frame(input int change_at, output logic [10:0] s, output int busy_hi);
    s = '0;
    busy_hi = 0;
    for (int j = 0; j < FB * C; j++) begin
      @(negedge clock);
      if (j % C == 2) s[j / C] = tx;
      if (busy === 1'b1) busy_hi++;
      if (j == change_at) begin
        data_in = 8'h00;
        ready_to_read = 1'b0;
      end
    end
  endtask

  task automatic pulse_reset();
    @(negedge clock);
    #1 rst = 1'b1;
    #1 rst = 1'b0;
  endtask

  initial begin
    logic [10:0] s;
    int          bh;
    int          lows;
    logic [7:0]  b;

    repeat (3) @(negedge clock);
    #1;
    check("reset_tx", tx, 1'b1);
    check("reset_busy", busy, 1'b0);
    check("reset_sent", sent, 1'b0);
    check("reset_state", state_dbg, 3'd0);
    rst = 1'b0;

    // Basic frame 0xA5
    @(negedge clock);
    data_in = 8'hA5;
    ready_to_read = 1'b1;
    sample_frame(-1, s, bh);
    check("a5_line", s, HasParity ? 11'h54A : 11'h34A);
    check("a5_busy_cycles", bh, FB * C);
    @(negedge clock);
    check("a5_sent", sent, 1'b1);

    // Hold ready high after DONE: no second frame
    lows = 0;
    repeat (200) begin
      @(negedge clock);
      if (tx !== 1'b1) lows++;
    end
    check("hold_no_restart", lows, 0);
    check("hold_sent", sent, 1'b1);

`ifdef PUF_TX_PARITY_EN
    pulse_reset();
    data_in = 8'h07;
    ready_to_read = 1'b1;
    sample_frame(-1, s, bh);
    check("p07_data", s[8:1], 8'h07);
    check("p07_parity", s[9], 1'b1);
`endif

    // Inputs change during data bit 3
    pulse_reset();
    data_in = 8'hA5;
    ready_to_read = 1'b1;
    sample_frame(4 * C + 1, s, bh);
    check("mid_change_data", s[8:1], 8'hA5);
    @(negedge clock);
    check("mid_change_sent", sent, 1'b1);

    // Reset during data bit 5, then a clean frame
    pulse_reset();
    b = 8'($urandom);
    data_in = b;
    ready_to_read = 1'b1;
    repeat (6 * C + 2) @(negedge clock);
    #1 rst = 1'b1;
    #1;
    check("abort_tx", tx, 1'b1);
    check("abort_busy", busy, 1'b0);
    check("abort_sent", sent, 1'b0);
    #1 rst = 1'b0;
    sample_frame(-1, s, bh);
    check("after_abort_data", s[8:1], b);
    check("after_abort_stop", s[FB-1], 1'b1);

    // Back-to-back ack cycles
    pulse_reset();
    data_in = 8'h3C;
    sample_frame(-1, s, bh);
    check("b2b_first", s[8:1], 8'h3C);
    @(negedge clock);
    check("b2b_sent1", sent, 1'b1);
    pulse_reset();
    #1 check("b2b_sent0", sent, 1'b0);
    data_in = 8'hF0;
    sample_frame(-1, s, bh);
    check("b2b_second", s[8:1], 8'hF0);
    @(negedge clock);
    check("b2b_sent2", sent, 1'b1);

    // Randomized traffic against the model
    for (int r = 0; r < 8; r++) begin
      ready_to_read = 1'($urandom);
      data_in = 8'($urandom);
      pulse_reset();
      repeat (150) begin
        @(negedge clock);
        if ($urandom_range(0, 9) == 0) ready_to_read = ~ready_to_read;
        if ($urandom_range(0, 3) == 0) data_in = 8'($urandom);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
